// File: rtl/reg_fetch_pkg.sv
// -----------------------------------------------------------------------------
// reg_fetch_pkg
// Shared definitions for the register-fetch stage: register file geometry,
// field widths, the nop encoding, the bundle carried to the execution units,
// and small combinational helpers (one-hot address decode, bypass read mux).
// No ports; imported by reg_fetch and reg_scoreboard.
// -----------------------------------------------------------------------------
package reg_fetch_pkg;

  localparam int REG_COUNT    = 128;
  localparam int REG_WIDTH    = 128;
  localparam int ADDR_WIDTH   = 7;
  localparam int OP_WIDTH     = 11;
  localparam int IMM_WIDTH    = 18;
  localparam int FORMAT_WIDTH = 3;

  // Nop encoding: format 0, op 0.
  localparam logic [0:OP_WIDTH-1]     NOP_OP     = 11'd0;
  localparam logic [FORMAT_WIDTH-1:0] NOP_FORMAT = 3'd0;

  typedef logic [0:REG_WIDTH-1]  reg_data_t;
  typedef logic [0:ADDR_WIDTH-1] reg_addr_t;

  // Everything the execution units see, registered as one unit.
  typedef struct packed {
    logic [0:OP_WIDTH-1]     op;
    logic [FORMAT_WIDTH-1:0] format;
    reg_addr_t               rt_addr;
    logic [0:IMM_WIDTH-1]    imm;
    logic                    reg_write;
    reg_data_t               ra;
    reg_data_t               rb;
    reg_data_t               rc;
  } ex_bundle_t;

  localparam ex_bundle_t EX_NOP = '{
    op:        NOP_OP,
    format:    NOP_FORMAT,
    rt_addr:   7'd0,
    imm:       18'd0,
    reg_write: 1'b0,
    ra:        128'd0,
    rb:        128'd0,
    rc:        128'd0
  };

  // Where a source operand is taken from.
  typedef enum logic [1:0] {
    SRC_RF      = 2'd0,
    SRC_WB_EVEN = 2'd1,
    SRC_WB_ODD  = 2'd2
  } rd_src_e;

  // One-hot mask of a register address, all zeros when not enabled.
  function automatic logic [REG_COUNT-1:0] addr_onehot(input reg_addr_t addr,
                                                       input logic      en);
    logic [REG_COUNT-1:0] mask;
    mask = {REG_COUNT{1'b0}};
    if (en) begin
      mask[addr] = 1'b1;
    end else begin
      mask = {REG_COUNT{1'b0}};
    end
    return mask;
  endfunction

  // Source read with same-cycle writeback forwarding; the odd pipe is younger
  // in program order, so it wins over the even pipe on an address tie.
  function automatic reg_data_t read_port(input reg_addr_t addr,
                                          input reg_data_t rf_val,
                                          input logic      even_en,
                                          input reg_addr_t even_addr,
                                          input reg_data_t even_data,
                                          input logic      odd_en,
                                          input reg_addr_t odd_addr,
                                          input reg_data_t odd_data);
    rd_src_e   src;
    reg_data_t val;
    if (odd_en && (addr == odd_addr)) begin
      src = SRC_WB_ODD;
    end else if (even_en && (addr == even_addr)) begin
      src = SRC_WB_EVEN;
    end else begin
      src = SRC_RF;
    end
    case (src)
      SRC_WB_ODD:  val = odd_data;
      SRC_WB_EVEN: val = even_data;
      SRC_RF:      val = rf_val;
      default:     val = rf_val;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/reg_fetch_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// One busy bit per architectural register. An issue sets the destination's
// bit, a writeback clears it; set wins over clear on the same register.
// Read ports report the busy state with this cycle's clears already applied,
// so an instruction whose producer writes back this cycle is not held.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   set_en_i / set_addr_i           mark a destination busy on issue
//   clr_even_* / clr_odd_*          clear on even / odd writeback
//   rd_{a,b,c,t}_addr_i             three source ports plus destination port
//   rd_{a,b,c,t}_busy_o             busy state for each read port
// -----------------------------------------------------------------------------
module reg_scoreboard
  import reg_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      set_en_i,
  input  reg_addr_t set_addr_i,
  input  logic      clr_even_en_i,
  input  reg_addr_t clr_even_addr_i,
  input  logic      clr_odd_en_i,
  input  reg_addr_t clr_odd_addr_i,
  input  reg_addr_t rd_a_addr_i,
  input  reg_addr_t rd_b_addr_i,
  input  reg_addr_t rd_c_addr_i,
  input  reg_addr_t rd_t_addr_i,
  output logic      rd_a_busy_o,
  output logic      rd_b_busy_o,
  output logic      rd_c_busy_o,
  output logic      rd_t_busy_o
);

  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;
  logic [REG_COUNT-1:0] clr_mask_s;
  logic [REG_COUNT-1:0] set_mask_s;
  logic [REG_COUNT-1:0] busy_eff_s;

  // Apply this cycle's clears first, then the issue set on top of them.
  always_comb begin
    clr_mask_s = addr_onehot(clr_even_addr_i, clr_even_en_i) |
                 addr_onehot(clr_odd_addr_i, clr_odd_en_i);
    set_mask_s = addr_onehot(set_addr_i, set_en_i);
    busy_eff_s = busy_q & ~clr_mask_s;
    busy_d     = busy_eff_s | set_mask_s;
  end

  assign rd_a_busy_o = busy_eff_s[rd_a_addr_i];
  assign rd_b_busy_o = busy_eff_s[rd_b_addr_i];
  assign rd_c_busy_o = busy_eff_s[rd_c_addr_i];
  assign rd_t_busy_o = busy_eff_s[rd_t_addr_i];

  // Busy-bit state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= {REG_COUNT{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/reg_fetch.sv
// -----------------------------------------------------------------------------
// reg_fetch
// Register-fetch stage: 128 x 128-bit register file with two writeback ports
// (even and odd pipes), same-cycle writeback forwarding, and a scoreboard that
// holds instructions with RAW or WAW hazards. Issued instructions appear on
// the *_ex outputs one cycle later; otherwise a nop is emitted.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   valid, op, format, imm, reg_write  decoded instruction from decode
//   ra/rb/rc/rt_addr                   source and destination addresses
//   rt_wb_*, rt_addr_wb_*,
//   reg_write_wb_*                     even/odd writeback ports
//   op_ex .. rc_ex                     registered outputs to execution units
//   stall                              combinational; decode must hold
// -----------------------------------------------------------------------------
module reg_fetch
  import reg_fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [0:OP_WIDTH-1]     op,
  input  logic [FORMAT_WIDTH-1:0] format,
  input  logic [0:IMM_WIDTH-1]    imm,
  input  logic                    reg_write,
  input  logic [0:ADDR_WIDTH-1]   ra_addr,
  input  logic [0:ADDR_WIDTH-1]   rb_addr,
  input  logic [0:ADDR_WIDTH-1]   rc_addr,
  input  logic [0:ADDR_WIDTH-1]   rt_addr,
  input  logic [0:REG_WIDTH-1]    rt_wb_even,
  input  logic [0:ADDR_WIDTH-1]   rt_addr_wb_even,
  input  logic                    reg_write_wb_even,
  input  logic [0:REG_WIDTH-1]    rt_wb_odd,
  input  logic [0:ADDR_WIDTH-1]   rt_addr_wb_odd,
  input  logic                    reg_write_wb_odd,
  output logic [0:OP_WIDTH-1]     op_ex,
  output logic [FORMAT_WIDTH-1:0] format_ex,
  output logic [0:ADDR_WIDTH-1]   rt_addr_ex,
  output logic [0:IMM_WIDTH-1]    imm_ex,
  output logic                    reg_write_ex,
  output logic [0:REG_WIDTH-1]    ra_ex,
  output logic [0:REG_WIDTH-1]    rb_ex,
  output logic [0:REG_WIDTH-1]    rc_ex,
  output logic                    stall
);

  reg_data_t  rf_q [REG_COUNT];
  ex_bundle_t ex_q;
  ex_bundle_t ex_d;

  logic      ra_busy_s;
  logic      rb_busy_s;
  logic      rc_busy_s;
  logic      rt_busy_s;
  logic      hazard_s;
  logic      issue_s;
  logic      set_en_s;
  reg_data_t ra_val_s;
  reg_data_t rb_val_s;
  reg_data_t rc_val_s;

  reg_scoreboard u_scoreboard (
    .clk             (clk),
    .reset           (reset),
    .set_en_i        (set_en_s),
    .set_addr_i      (rt_addr),
    .clr_even_en_i   (reg_write_wb_even),
    .clr_even_addr_i (rt_addr_wb_even),
    .clr_odd_en_i    (reg_write_wb_odd),
    .clr_odd_addr_i  (rt_addr_wb_odd),
    .rd_a_addr_i     (ra_addr),
    .rd_b_addr_i     (rb_addr),
    .rd_c_addr_i     (rc_addr),
    .rd_t_addr_i     (rt_addr),
    .rd_a_busy_o     (ra_busy_s),
    .rd_b_busy_o     (rb_busy_s),
    .rd_c_busy_o     (rc_busy_s),
    .rd_t_busy_o     (rt_busy_s)
  );

  // Hazard detection and issue decision; reset suppresses both stall and issue.
  always_comb begin
    hazard_s = ra_busy_s | rb_busy_s | rc_busy_s | (reg_write & rt_busy_s);
    if (reset) begin
      stall   = 1'b0;
      issue_s = 1'b0;
    end else begin
      stall   = valid & hazard_s;
      issue_s = valid & ~hazard_s;
    end
    set_en_s = issue_s & reg_write;
  end

  // Operand reads with writeback forwarding.
  always_comb begin
    ra_val_s = read_port(ra_addr, rf_q[ra_addr],
                         reg_write_wb_even, rt_addr_wb_even, rt_wb_even,
                         reg_write_wb_odd, rt_addr_wb_odd, rt_wb_odd);
    rb_val_s = read_port(rb_addr, rf_q[rb_addr],
                         reg_write_wb_even, rt_addr_wb_even, rt_wb_even,
                         reg_write_wb_odd, rt_addr_wb_odd, rt_wb_odd);
    rc_val_s = read_port(rc_addr, rf_q[rc_addr],
                         reg_write_wb_even, rt_addr_wb_even, rt_wb_even,
                         reg_write_wb_odd, rt_addr_wb_odd, rt_wb_odd);
  end

  // Next execution bundle: the instruction when issued, otherwise a nop.
  always_comb begin
    ex_d = EX_NOP;
    if (issue_s) begin
      ex_d.op        = op;
      ex_d.format    = format;
      ex_d.rt_addr   = rt_addr;
      ex_d.imm       = imm;
      ex_d.reg_write = reg_write;
      ex_d.ra        = ra_val_s;
      ex_d.rb        = rb_val_s;
      ex_d.rc        = rc_val_s;
    end else begin
      ex_d = EX_NOP;
    end
  end

  // Register file write; the odd write is ordered last so it wins a tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        rf_q[i] <= {REG_WIDTH{1'b0}};
      end
    end else begin
      if (reg_write_wb_even) begin
        rf_q[rt_addr_wb_even] <= rt_wb_even;
      end
      if (reg_write_wb_odd) begin
        rf_q[rt_addr_wb_odd] <= rt_wb_odd;
      end
    end
  end

  // Execution-stage output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= EX_NOP;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign op_ex        = ex_q.op;
  assign format_ex    = ex_q.format;
  assign rt_addr_ex   = ex_q.rt_addr;
  assign imm_ex       = ex_q.imm;
  assign reg_write_ex = ex_q.reg_write;
  assign ra_ex        = ex_q.ra;
  assign rb_ex        = ex_q.rb;
  assign rc_ex        = ex_q.rc;

endmodule

// File: doc/reg_fetch.md
REG_FETCH -- requirements
Module: reg_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-003 SHALL have port valid, input, 1 bit, meaning the decode stage presents an instruction this cycle.
REQ-004 SHALL have ports op [0:10], format [2:0], imm [0:17], reg_write [1], all inputs carrying the decoded instruction fields.
REQ-005 SHALL have ports ra_addr, rb_addr, rc_addr, rt_addr, each an input of [0:6], giving the source and destination register addresses.
REQ-006 SHALL have writeback inputs rt_wb_even [0:127], rt_addr_wb_even [0:6], reg_write_wb_even [1], and an identical odd-pipe set suffixed _odd.
REQ-007 SHALL have outputs op_ex [0:10], format_ex [2:0], rt_addr_ex [0:6], imm_ex [0:17], reg_write_ex [1] and ra_ex, rb_ex, rc_ex [0:127], all driving the execution units.
REQ-008 SHALL have output stall [1], meaning the presented instruction was not issued and decode must hold it.

Function
REQ-009 SHALL hold 128 registers of 128 bits, addressed 0..127.
REQ-010 SHALL write each writeback port with reg_write_wb_* = 1 into its register at posedge.
REQ-011 SHALL store the odd-pipe value when both ports write the same address in one cycle.
REQ-012 SHALL bypass writes to reads: a source address matching an active writeback address in the same cycle reads the writeback data, with odd taking priority over even.
REQ-013 SHALL register all *_ex outputs, giving 1-cycle latency from the issue cycle to the values appearing on the outputs.
REQ-014 SHALL keep a 128-bit scoreboard with one busy bit per register.
REQ-015 SHALL assert stall combinationally when valid = 1 and the busy bit of ra_addr, rb_addr or rc_addr is set after the same-cycle writeback clear has been applied.
REQ-016 SHALL also assert stall when valid = 1, reg_write = 1 and rt_addr is busy, to prevent WAW hazards.
REQ-017 SHALL issue the instruction when valid = 1 and stall = 0: *_ex take the input fields and the read data, and the busy bit of rt_addr is set if reg_write = 1.
REQ-018 SHALL emit a nop when the instruction is not issued (valid = 0 or stall = 1): op_ex = 0, format_ex = 0, reg_write_ex = 0, rt_addr_ex = 0, imm_ex = 0, ra_ex/rb_ex/rc_ex = 0.
REQ-019 SHALL clear the busy bit of a register on a writeback with reg_write_wb_* = 1 to that register.
REQ-020 SHALL let set win over clear when a writeback clears and an issue sets the same register in one cycle.
REQ-021 SHALL not check source addresses of an instruction that does not use them; unused fields arrive as 0, and register 0 is treated like any other register.

Reset
REQ-022 SHALL clear, while reset = 1 at posedge, all 128 registers, all busy bits and all *_ex outputs to 0.
REQ-023 SHALL drive stall = 0 while reset = 1.
REQ-024 SHALL discard writebacks and issues presented in a reset cycle.
REQ-025 SHALL resume normal operation on the first posedge with reset = 0.

Structure
REQ-026 SHALL place in a shared package: REG_COUNT = 128, REG_WIDTH = 128, ADDR_WIDTH = 7, OP_WIDTH = 11, IMM_WIDTH = 18, and the nop encoding (format 0, op 0).
REQ-027 SHALL implement the scoreboard as one sub-module, reg_scoreboard, with set and clear ports and three read ports plus one destination read port.

Verification
REQ-028 SHALL check: reset, then read ra_addr = 5 -> ra_ex = 0 one cycle later.
REQ-029 SHALL check: even writeback to r5 with value 0xAA..AA, and in the same cycle issue of ra_addr = 5 -> ra_ex = 0xAA..AA (bypass).
REQ-030 SHALL check: issue with rt_addr = 9, reg_write = 1, then next issue with ra_addr = 9 -> stall = 1 and a nop emitted until the r9 writeback; on the writeback cycle stall = 0 and ra_ex = the writeback value.
REQ-031 SHALL check: even and odd writebacks to r3 in the same cycle, values 1 and 2 -> a later read of r3 returns 2.
REQ-032 SHALL check: r7 busy, then in one cycle a writeback clears r7 and an issue sets rt_addr = 7 -> r7 remains busy (a dependent read stalls).
REQ-033 SHALL check: reset asserted while r4 is busy -> all busy bits clear and a read of r4 after reset returns 0 with no stall.
